// File: rtl/ahb_board_inputs_pkg.sv
// Shared constants for the board-inputs AHB-Lite slave: register word
// addresses, the default debounce length and the idle HTRANS encoding.
package board_inputs_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 500_000;

    // Word addresses decoded from HADDR[3:2]
    localparam logic [1:0] SW_STATE_ADDR  = 2'd0;
    localparam logic [1:0] KEY_STATE_ADDR = 2'd1;
    localparam logic [1:0] KEY_EVENT_ADDR = 2'd2;
    localparam logic [1:0] STATUS_ADDR    = 2'd3;

    // HTRANS value for "no transfer"
    localparam logic [1:0] HTRANS_IDLE = 2'b00;

    // STATUS layout: bit0 = any press flag, [15:8] = press counter
    function automatic logic [31:0] status_word(input logic any_flag, input logic [7:0] press_cnt);
        return {16'h0000, press_cnt, 7'b0000000, any_flag};
    endfunction

endpackage

// File: rtl/ahb_board_inputs_if.sv
// AHB-Lite bus signals seen by the board-inputs slave.
interface ahb_board_inputs_if;

    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic        HREADY;
    logic        HSEL;
    logic [31:0] HRDATA;
    logic        HREADYOUT;

    // Handshake: a transfer is accepted on a rising edge when HREADY && HSEL &&
    // HTRANS != IDLE; its data phase follows on the next cycle. The slave never
    // stalls (HREADYOUT = 1), so read data is valid in that data-phase cycle and
    // write data is taken at the end of it.
    modport master (
        output HADDR, HWDATA, HSIZE, HTRANS, HWRITE, HREADY, HSEL,
        input  HRDATA, HREADYOUT
    );

    modport slave (
        input  HADDR, HWDATA, HSIZE, HTRANS, HWRITE, HREADY, HSEL,
        output HRDATA, HREADYOUT
    );

endinterface

// File: rtl/ahb_board_inputs_debounce.sv
// One-bit two-flop synchroniser followed by a stable-count debouncer.
// rise_o pulses in the cycle whose closing edge moves the level 0 -> 1.
module input_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          differ, done;

    // Synchroniser, debounced level and stability counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // Count while the synced input disagrees; accept it after DEBOUNCE_CYCLES
    always_comb begin
        differ  = (sync2_q != level_q);
        done    = differ && (cnt_q == LAST);
        cnt_d   = cnt_q;
        level_d = level_q;
        if (!differ || done) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        if (done) begin
            level_d = sync2_q;
        end
        rise_o = done && sync2_q;
    end

    assign level_o = level_q;

endmodule

// File: rtl/ahb_board_inputs.sv
// AHB-Lite read-side board I/O: debounced switches and keys, sticky W1C
// press flags, an 8-bit press counter and a registered press interrupt.
module ahb_board_inputs
    import board_inputs_pkg::*;
#(
    parameter int SW_W            = 10,
    parameter int KEY_W           = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    ahb_board_inputs_if.slave    bus,
    input  logic [SW_W-1:0]      SW,
    input  logic [KEY_W-1:0]     KEY,
    output logic                 KEY_IRQ
);

    logic             write_enable_q, write_enable_d;
    logic             read_enable_q, read_enable_d;
    logic [1:0]       word_address_q, word_address_d;
    logic [KEY_W-1:0] flags_q, flags_d, flag_clr;
    logic [7:0]       press_cnt_q, press_cnt_d;
    logic             irq_q;
    logic [SW_W-1:0]  sw_state, unused_sw_rise;
    logic [KEY_W-1:0] key_state, key_rise;
    logic [31:0]      rdata;

    for (genvar i = 0; i < SW_W; i++) begin : g_sw
        input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk_i  (HCLK),
            .rst_ni (HRESETn),
            .raw_i  (SW[i]),
            .level_o(sw_state[i]),
            .rise_o (unused_sw_rise[i])
        );
    end

    // Keys are active-low on the board; invert so 1 = pressed from here on
    for (genvar i = 0; i < KEY_W; i++) begin : g_key
        input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk_i  (HCLK),
            .rst_ni (HRESETn),
            .raw_i  (~KEY[i]),
            .level_o(key_state[i]),
            .rise_o (key_rise[i])
        );
    end

    // Address phase capture; anything other than a selected active transfer clears it
    always_comb begin
        write_enable_d = 1'b0;
        read_enable_d  = 1'b0;
        word_address_d = 2'd0;
        if (bus.HREADY && bus.HSEL && (bus.HTRANS != HTRANS_IDLE)) begin
            write_enable_d = bus.HWRITE;
            read_enable_d  = ~bus.HWRITE;
            word_address_d = bus.HADDR[3:2];
        end
    end

    // Flag update: a new press wins over a same-cycle W1C clear
    always_comb begin
        flag_clr = '0;
        if (write_enable_q && (word_address_q == KEY_EVENT_ADDR)) begin
            flag_clr = bus.HWDATA[KEY_W-1:0];
        end
        flags_d     = (flags_q & ~flag_clr) | key_rise;
        press_cnt_d = press_cnt_q + {7'd0, |key_rise};
    end

    // Bus phase, flags, counter and interrupt registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            write_enable_q <= 1'b0;
            read_enable_q  <= 1'b0;
            word_address_q <= 2'd0;
            flags_q        <= '0;
            press_cnt_q    <= 8'd0;
            irq_q          <= 1'b0;
        end else begin
            write_enable_q <= write_enable_d;
            read_enable_q  <= read_enable_d;
            word_address_q <= word_address_d;
            flags_q        <= flags_d;
            press_cnt_q    <= press_cnt_d;
            irq_q          <= |flags_q;
        end
    end

    // Read mux, zero outside a read data phase
    always_comb begin
        rdata = 32'h0;
        if (read_enable_q) begin
            case (word_address_q)
                SW_STATE_ADDR:  rdata[SW_W-1:0]  = sw_state;
                KEY_STATE_ADDR: rdata[KEY_W-1:0] = key_state;
                KEY_EVENT_ADDR: rdata[KEY_W-1:0] = flags_q;
                default:        rdata = status_word(|flags_q, press_cnt_q);
            endcase
        end
    end

    assign bus.HRDATA    = rdata;
    assign bus.HREADYOUT = 1'b1;
    assign KEY_IRQ       = irq_q;

    logic unused_bits;
    assign unused_bits = &{1'b0, bus.HADDR[31:4], bus.HADDR[1:0], bus.HSIZE,
                           bus.HWDATA[31:KEY_W], unused_sw_rise};

endmodule

// File: tb/tb_ahb_board_inputs.sv
// Directed bench for ahb_board_inputs with a short debounce (4 cycles).
module tb_ahb_board_inputs;

    localparam int SW_W  = 10;
    localparam int KEY_W = 4;
    localparam int DB    = 4;

    logic             HCLK;
    logic             HRESETn;
    logic [SW_W-1:0]  SW;
    logic [KEY_W-1:0] KEY;
    logic             KEY_IRQ;

    int n_checks = 0;
    int n_fail   = 0;

    ahb_board_inputs_if bus ();

    ahb_board_inputs #(
        .SW_W           (SW_W),
        .KEY_W          (KEY_W),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .bus    (bus),
        .SW     (SW),
        .KEY    (KEY),
        .KEY_IRQ(KEY_IRQ)
    );

    // Clock and watchdog
    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
        bus.HADDR  = 32'h0;
    endtask

    // Starts the address phase; caller is at a negedge
    task automatic addr_phase(input logic [1:0] word, input logic wr);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HWRITE = wr;
        bus.HADDR  = {28'h0000000, word, 2'b00};
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge HCLK);
        @(negedge HCLK);
    endtask

    task automatic read_chk(input string tag, input logic [1:0] word, input logic [31:0] exp);
        addr_phase(word, 1'b0);
        @(posedge HCLK);
        @(negedge HCLK);
        bus_idle();
        check_eq(tag, bus.HRDATA, exp);
        check_eq({tag, "_hreadyout"}, {31'd0, bus.HREADYOUT}, 32'd1);
    endtask

    task automatic bus_write(input logic [1:0] word, input logic [31:0] data);
        addr_phase(word, 1'b1);
        @(posedge HCLK);
        @(negedge HCLK);
        bus_idle();
        bus.HWDATA = data;
        @(posedge HCLK);
        @(negedge HCLK);
    endtask

    initial begin
        HRESETn    = 1'b0;
        SW         = '0;
        KEY        = 4'hF;
        bus.HREADY = 1'b1;
        bus.HSIZE  = 3'b010;
        bus.HWDATA = 32'h0;
        bus_idle();

        // Reset state
        wait_cyc(3);
        check_eq("rst_hrdata", bus.HRDATA, 32'h0);
        check_eq("rst_irq", {31'd0, KEY_IRQ}, 32'd0);
        check_eq("rst_hreadyout", {31'd0, bus.HREADYOUT}, 32'd1);
        HRESETn = 1'b1;
        wait_cyc(2);
        read_chk("idle_sw", 2'd0, 32'h0);
        read_chk("idle_key", 2'd1, 32'h0);
        read_chk("idle_evt", 2'd2, 32'h0);
        read_chk("idle_status", 2'd3, 32'h0);
        check_eq("idle_irq", {31'd0, KEY_IRQ}, 32'd0);

        // Switch latency: visible at edge 6, not edge 5
        addr_phase(2'd0, 1'b0);
        SW = 10'h2A5;
        repeat (5) @(posedge HCLK);
        @(negedge HCLK);
        check_eq("sw_edge5", bus.HRDATA, 32'h0);
        wait_cyc(1);
        check_eq("sw_edge6", bus.HRDATA, 32'h2A5);
        bus_idle();

        // Three-cycle glitch on SW[0] is rejected
        SW[0] = 1'b0;
        wait_cyc(3);
        SW[0] = 1'b1;
        wait_cyc(10);
        read_chk("sw_glitch", 2'd0, 32'h2A5);

        // KEY[1] press: level, flag and one-cycle-late interrupt
        addr_phase(2'd1, 1'b0);
        KEY = 4'b1101;
        repeat (5) @(posedge HCLK);
        @(negedge HCLK);
        check_eq("key_edge5", bus.HRDATA, 32'h0);
        wait_cyc(1);
        check_eq("key_edge6", bus.HRDATA, 32'h2);
        check_eq("irq_edge6", {31'd0, KEY_IRQ}, 32'd0);
        wait_cyc(1);
        check_eq("irq_edge7", {31'd0, KEY_IRQ}, 32'd1);
        bus_idle();
        wait_cyc(3);
        KEY = 4'hF;
        wait_cyc(8);
        read_chk("key_released", 2'd1, 32'h0);
        read_chk("evt_after_rel", 2'd2, 32'h2);
        read_chk("status_1", 2'd3, 32'h0000_0101);

        // W1C clear, interrupt falls a cycle after the flag
        bus_write(2'd2, 32'h2);
        check_eq("irq_after_clr0", {31'd0, KEY_IRQ}, 32'd1);
        wait_cyc(1);
        check_eq("irq_after_clr1", {31'd0, KEY_IRQ}, 32'd0);
        read_chk("evt_cleared", 2'd2, 32'h0);
        read_chk("status_cleared", 2'd3, 32'h0000_0100);

        // Writes to read-only registers are ignored
        bus_write(2'd0, 32'hFF);
        read_chk("sw_ro", 2'd0, 32'h2A5);

        // W1C in the same cycle as the KEY[0] rise: set wins
        KEY = 4'b1110;
        wait_cyc(4);
        bus_write(2'd2, 32'h1);
        read_chk("evt_set_wins", 2'd2, 32'h1);
        KEY = 4'hF;
        wait_cyc(8);
        read_chk("status_2", 2'd3, 32'h0000_0201);
        bus_write(2'd2, 32'hF);
        read_chk("evt_all_clr", 2'd2, 32'h0);

        // 256 presses of KEY[2]: counter wraps back to its starting value
        for (int i = 0; i < 256; i++) begin
            KEY = 4'b1011;
            wait_cyc(7);
            KEY = 4'hF;
            wait_cyc(7);
            if (i == 253) read_chk("status_wrap0", 2'd3, 32'h0000_0001);
        end
        read_chk("status_256", 2'd3, 32'h0000_0201);
        read_chk("evt_key2", 2'd2, 32'h4);

        // Two keys rising together count once
        KEY = 4'b0110;
        wait_cyc(7);
        KEY = 4'hF;
        wait_cyc(7);
        read_chk("status_dual", 2'd3, 32'h0000_0301);
        read_chk("evt_dual", 2'd2, 32'hD);
        check_eq("irq_dual", {31'd0, KEY_IRQ}, 32'd1);

        // Reset mid-debounce: everything clears, full re-debounce afterwards
        SW  = '0;
        KEY = 4'b1101;
        wait_cyc(3);
        HRESETn = 1'b0;
        #1;
        check_eq("midrst_irq", {31'd0, KEY_IRQ}, 32'd0);
        check_eq("midrst_hrdata", bus.HRDATA, 32'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        read_chk("post_rst_evt", 2'd2, 32'h0);
        read_chk("post_rst_status", 2'd3, 32'h0);
        read_chk("post_rst_sw", 2'd0, 32'h0);
        addr_phase(2'd1, 1'b0);
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        check_eq("redb_edge5", bus.HRDATA, 32'h0);
        wait_cyc(1);
        check_eq("redb_edge6", bus.HRDATA, 32'h2);
        bus_idle();
        wait_cyc(1);
        read_chk("post_rst_status2", 2'd3, 32'h0000_0101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_board_inputs.md
Name: ahb_board_inputs

Overview:
AHB-Lite slave that is the read side of the board I/O, the counterpart of the write-only display peripheral. It synchronises and debounces the slide switches and push-buttons, and latches button-press events into sticky flags. It counts presses and exposes all of this to the processor as word registers with zero-wait-state reads. It sits on the AHB-Lite bus alongside the display slave, with its own HSEL.

Parameters:
SW_W, 10, number of slide switches (1..16)
KEY_W, 4, number of push-buttons (1..8)
DEBOUNCE_CYCLES, 500_000, stable cycles required before a debounced input changes (>=2; the bench uses 4)

Ports:
HCLK  input  1  system clock
HRESETn  input  1  asynchronous active-low reset
HADDR  input  32  address; only HADDR[3:2] decoded
HWDATA  input  32  write data
HSIZE  input  3  ignored; word transfers only
HTRANS  input  2  transfer type
HWRITE  input  1  1 = write
HREADY  input  1  bus ready
HSEL  input  1  slave select
HRDATA  output  32  read data, valid in data phase
HREADYOUT  output  1  tied 1
SW  input  SW_W  raw slide switches, active-high, asynchronous
KEY  input  KEY_W  raw push-buttons, active-low (0 = pressed), asynchronous
KEY_IRQ  output  1  registered OR of press flags

Behaviour:
- Clock and reset: one clock, HCLK; reset HRESETn is asynchronous and active-low.
- Reset values:
  - all synchroniser flops, debounce counters, debounced switch state, press flags and press counter are 0;
  - keys reset as released;
  - HRDATA = 0, KEY_IRQ = 0.
- Address phase: when HREADY && HSEL && HTRANS != 2'b00, register HWRITE (as write_enable), HWRITE inverted (as read_enable) and HADDR[3:2] (as word_address). Otherwise clear all three.
- Data phase:
  - HRDATA is combinational from read_enable/word_address, and 0 when read_enable = 0.
  - HREADYOUT is always 1.
  - Reads have no side effects.
- Register map (unused bits read 0):
  - +0 SW_STATE (RO): [SW_W-1:0] = debounced switches.
  - +4 KEY_STATE (RO): [KEY_W-1:0] = debounced keys, 1 = pressed.
  - +8 KEY_EVENT (R/W1C): [KEY_W-1:0] = sticky press flags. A write clears every flag whose HWDATA bit is 1.
  - +12 STATUS (RO): bit0 = |KEY_EVENT; [15:8] = press counter.
  - Writes to +0, +4 and +12 are ignored.
- Input path per bit:
  - Two-flop synchroniser. KEY is inverted before synchronising.
  - Debouncer: counter clears whenever synced == debounced. While they differ, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the inputs still differing, debounced <= synced and the counter clears.
  - Latency: a raw change held stable appears at the debounced output DEBOUNCE_CYCLES+2 rising edges after the raw change.
  - A glitch shorter than DEBOUNCE_CYCLES synced cycles produces no change.
- Press events:
  - A rising edge on a debounced key (released -> pressed) sets that key's flag in the same cycle the debounced level changes.
  - Releases set nothing.
- Press counter:
  - 8-bit; +1 in any cycle with at least one key rising edge, regardless of how many keys rise.
  - Wraps 255 -> 0; never cleared except by reset.
- Simultaneous events: a flag set and a W1C clear of the same bit in the same cycle leaves the bit set.
- KEY_IRQ is registered |flags, one cycle behind the flags.
- Reset mid-debounce or mid-transfer: everything returns to its reset value immediately. A subsequently held input requires the full DEBOUNCE_CYCLES+2 edges again. No stale bus phase survives reset.

Decomposition:
- Package board_inputs_pkg: register offset constants (SW_STATE_ADDR=0, KEY_STATE_ADDR=1, KEY_EVENT_ADDR=2, STATUS_ADDR=3 as word addresses), DEBOUNCE_CYCLES default, HTRANS No_Transfer constant.
- Sub-module input_debounce (parameter DEBOUNCE_CYCLES): 1-bit synchroniser plus debouncer, outputs the debounced level and a one-cycle rise pulse. Instantiated SW_W+KEY_W times via generate.
- Top-level holds the AHB decode, flags, counter and read mux.

Test Plan:
- Reset, then read +0, +4, +8, +12 with all inputs idle (SW=0, KEY=4'hF) -> all read 0x00000000; KEY_IRQ=0; HREADYOUT=1 throughout.
- DEBOUNCE_CYCLES=4: SW goes 0 -> 10'h2A5 and holds -> +0 reads 0x2A5 from edge 6 onward, and still reads 0 at edge 5. A 3-cycle pulse on SW[0] produces no change.
- KEY[1] pressed (driven 0) for 10 cycles, then released -> +4 reads 0x2 while held. +8 reads 0x2 after release. +12 reads 0x00000101. KEY_IRQ rises one cycle after the flag.
- Write 0x2 to +8 -> +8 reads 0. STATUS bit0 = 0 while [15:8] stays 0x01. KEY_IRQ falls one cycle later. Writing 0xFF to +0 leaves SW_STATE unchanged.
- W1C of bit 0 issued in the same cycle the KEY[0] debounced rise occurs -> flag 0 reads 1 afterwards.
- 256 separate presses of KEY[2] -> counter reads 0x00. Pressing KEY[0] and KEY[3] in the same cycle -> counter +1 only. Asserting HRESETn low mid-debounce -> all registers 0 and a full re-debounce is required.
